// File: rtl/ll_pkg.sv
// rtl/ll_pkg.sv - shared FSM state type and link-field constants for ll_outport
package ll_pkg;

  localparam int LL_LPSZ = 8;
  // Stop bit sits directly above the page number in the default link field.
  localparam int LL_STOP_IDX = LL_LPSZ;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RSP,
    ST_OUT,
    ST_FREE
  } ll_state_e;

  function automatic int ll_stop_idx(input int lpdsz);
    return lpdsz - 1;
  endfunction

endpackage

// File: rtl/ll_outport_if.sv
// rtl/ll_outport_if.sv - handshake bundle between ll_outport and its queue, link manager, sink and free list
interface ll_outport_if import ll_pkg::*; #(
  parameter int lpsz  = LL_LPSZ,
  parameter int lpdsz = lpsz + 1
);

  logic             ip_srdy;
  logic             ip_drdy;
  logic [lpsz-1:0]  ip_page;
  logic             rlp_srdy;
  logic             rlp_drdy;
  logic [lpsz-1:0]  rlp_page;
  logic             rlpr_srdy;
  logic             rlpr_drdy;
  logic [lpdsz-1:0] rlpr_data;
  logic             op_srdy;
  logic             op_drdy;
  logic [lpsz-1:0]  op_page;
  logic             op_eop;
  logic             drf_srdy;
  logic             drf_drdy;
  logic [lpsz-1:0]  drf_page;
  logic             pkt_done;
  logic [15:0]      pkt_count;

  modport master (
    input  ip_srdy, ip_page, rlp_drdy, rlpr_srdy, rlpr_data, op_drdy, drf_drdy,
    output ip_drdy, rlp_srdy, rlp_page, rlpr_drdy, op_srdy, op_page, op_eop,
           drf_srdy, drf_page, pkt_done, pkt_count
  );

  modport slave (
    output ip_srdy, ip_page, rlp_drdy, rlpr_srdy, rlpr_data, op_drdy, drf_drdy,
    input  ip_drdy, rlp_srdy, rlp_page, rlpr_drdy, op_srdy, op_page, op_eop,
           drf_srdy, drf_page, pkt_done, pkt_count
  );

endinterface

// File: rtl/ll_pktcnt.sv
// rtl/ll_pktcnt.sv - wrapping 16-bit completed-packet counter, present only with LL_OUTPORT_STATS_EN
`ifdef LL_OUTPORT_STATS_EN
module ll_pktcnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/ll_outport.sv
// rtl/ll_outport.sv - walks a linked list of pages: read link, emit page, free page; stats via LL_OUTPORT_STATS_EN
module ll_outport import ll_pkg::*; #(
  parameter int lpsz  = LL_LPSZ,
  parameter int lpdsz = lpsz + 1
) (
  input logic          clk,
  input logic          reset,
  ll_outport_if.master bus
);

  localparam int stop_idx = ll_stop_idx(lpdsz);

  ll_state_e       state;
  logic [lpsz-1:0] cur;
  logic [lpsz-1:0] nxt_page;
  logic            nxt_stop;

  logic            ip_drdy;
  logic            rlp_srdy;
  logic [lpsz-1:0] rlp_page;
  logic            rlpr_drdy;
  logic            op_srdy;
  logic [lpsz-1:0] op_page;
  logic            op_eop;
  logic            drf_srdy;
  logic [lpsz-1:0] drf_page;
  logic            pkt_done;

  // Handshake outputs are registered alongside the state so each is a clean flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur       <= '0;
      nxt_page  <= '0;
      nxt_stop  <= 1'b0;
      ip_drdy   <= 1'b1;
      rlp_srdy  <= 1'b0;
      rlp_page  <= '0;
      rlpr_drdy <= 1'b0;
      op_srdy   <= 1'b0;
      op_page   <= '0;
      op_eop    <= 1'b0;
      drf_srdy  <= 1'b0;
      drf_page  <= '0;
      pkt_done  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.ip_srdy) begin
            cur      <= bus.ip_page;
            rlp_page <= bus.ip_page;
            ip_drdy  <= 1'b0;
            rlp_srdy <= 1'b1;
            state    <= ST_RD;
          end
        end
        ST_RD: begin
          if (bus.rlp_drdy) begin
            rlp_srdy  <= 1'b0;
            rlpr_drdy <= 1'b1;
            state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          // Only the stop bit and page bits are kept; anything between is dropped.
          if (bus.rlpr_srdy) begin
            nxt_page  <= bus.rlpr_data[lpsz-1:0];
            nxt_stop  <= bus.rlpr_data[stop_idx];
            rlpr_drdy <= 1'b0;
            op_srdy   <= 1'b1;
            op_page   <= cur;
            op_eop    <= bus.rlpr_data[stop_idx];
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.op_drdy) begin
            op_srdy  <= 1'b0;
            op_eop   <= 1'b0;
            drf_srdy <= 1'b1;
            drf_page <= cur;
            state    <= ST_FREE;
          end
        end
        ST_FREE: begin
          if (bus.drf_drdy) begin
            drf_srdy <= 1'b0;
            if (nxt_stop) begin
              pkt_done <= 1'b1;
              ip_drdy  <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              cur      <= nxt_page;
              rlp_page <= nxt_page;
              rlp_srdy <= 1'b1;
              state    <= ST_RD;
            end
          end
        end
        default: begin
          ip_drdy   <= 1'b1;
          rlp_srdy  <= 1'b0;
          rlpr_drdy <= 1'b0;
          op_srdy   <= 1'b0;
          drf_srdy  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ip_drdy   = ip_drdy;
  assign bus.rlp_srdy  = rlp_srdy;
  assign bus.rlp_page  = rlp_page;
  assign bus.rlpr_drdy = rlpr_drdy;
  assign bus.op_srdy   = op_srdy;
  assign bus.op_page   = op_page;
  assign bus.op_eop    = op_eop;
  assign bus.drf_srdy  = drf_srdy;
  assign bus.drf_page  = drf_page;
  assign bus.pkt_done  = pkt_done;

`ifdef LL_OUTPORT_STATS_EN
  logic [15:0] pkt_count;

  ll_pktcnt u_pktcnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pkt_done),
    .count (pkt_count)
  );

  assign bus.pkt_count = pkt_count;
`else
  assign bus.pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_ll_outport.sv
// tb/tb_ll_outport.sv - scoreboard bench for ll_outport with modelled queue, link manager, sink and free list
module tb_ll_outport;
  import ll_pkg::*;

  localparam int LPSZ  = LL_LPSZ;
  localparam int LPDSZ = LPSZ + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ll_outport_if #(.lpsz(LPSZ), .lpdsz(LPDSZ)) bus ();

  ll_outport #(.lpsz(LPSZ), .lpdsz(LPDSZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int bp = 0;
  bit hold_drf = 1'b0;
  bit hold_op  = 1'b0;
  int cyc = 0;
  int model_cnt = 0;
  int done_cnt = 0;
  int t_ip = 0;
  int t_done = 0;
  bit done_ipdrdy = 1'b0;

  logic [LPSZ-1:0]  hq[$];
  logic [LPSZ-1:0]  exp_rlp[$];
  logic [LPDSZ-1:0] exp_lnk[$];
  logic [LPDSZ-1:0] rsp_q[$];
  logic [LPSZ:0]    exp_op[$];
  logic [LPSZ-1:0]  exp_drf[$];
  bit               exp_last[$];

  function automatic logic [15:0] exp_count();
`ifdef LL_OUTPORT_STATS_EN
    return 16'(model_cnt);
`else
    return 16'd0;
`endif
  endfunction

  task automatic add_pkt(input int n, input logic [LPSZ-1:0] p0, input logic [LPSZ-1:0] p1,
                         input logic [LPSZ-1:0] p2, input logic [LPSZ-1:0] tail);
    logic [LPSZ-1:0] pg[3];
    pg[0] = p0;
    pg[1] = p1;
    pg[2] = p2;
    hq.push_back(p0);
    for (int i = 0; i < n; i++) begin
      exp_rlp.push_back(pg[i]);
      if (i == n - 1) exp_lnk.push_back({1'b1, tail});
      else            exp_lnk.push_back({1'b0, pg[i+1]});
      exp_op.push_back({(i == n - 1), pg[i]});
      exp_drf.push_back(pg[i]);
      exp_last.push_back(i == n - 1);
    end
  endtask

  // Peer models: observe transfers at negedge, drive the next cycle's inputs just after posedge.
  initial begin : peer
    bit f_ip, f_rlp, f_rsp, f_op, f_drf;
    bit p_rlp, p_op, p_drf;
    logic [LPSZ-1:0] p_rlp_pg, p_op_pg, p_drf_pg, e;
    logic p_eop;
    logic [LPSZ:0] eo;
    int hs;
    bus.ip_srdy = 1'b0; bus.ip_page = '0; bus.rlp_drdy = 1'b0; bus.rlpr_srdy = 1'b0;
    bus.rlpr_data = '0; bus.op_drdy = 1'b0; bus.drf_drdy = 1'b0;
    p_rlp = 0; p_op = 0; p_drf = 0; p_rlp_pg = '0; p_op_pg = '0; p_drf_pg = '0; p_eop = 0;
    forever begin
      @(negedge clk);
      cyc++;
      f_ip = 0; f_rlp = 0; f_rsp = 0; f_op = 0; f_drf = 0;
      if (!reset) begin
        f_ip  = bus.ip_srdy && bus.ip_drdy;
        f_rlp = bus.rlp_srdy && bus.rlp_drdy;
        f_rsp = bus.rlpr_srdy && bus.rlpr_drdy;
        f_op  = bus.op_srdy && bus.op_drdy;
        f_drf = bus.drf_srdy && bus.drf_drdy;
        hs = $countones({bus.ip_drdy, bus.rlp_srdy, bus.rlpr_drdy, bus.op_srdy, bus.drf_srdy});
        n_cmp++;
        if (hs !== 1) begin n_bad++; $display("FAIL handshake_onehot cyc %0d: %0d high, want 1", cyc, hs); end
        if (p_rlp) begin
          n_cmp++;
          if (!(bus.rlp_srdy === 1'b1 && bus.rlp_page === p_rlp_pg)) begin
            n_bad++; $display("FAIL rlp_hold: srdy=%b page=%h, want 1/%h", bus.rlp_srdy, bus.rlp_page, p_rlp_pg);
          end
        end
        if (p_op) begin
          n_cmp++;
          if (!(bus.op_srdy === 1'b1 && bus.op_page === p_op_pg && bus.op_eop === p_eop)) begin
            n_bad++; $display("FAIL op_hold: srdy=%b page=%h eop=%b, want 1/%h/%b", bus.op_srdy, bus.op_page, bus.op_eop, p_op_pg, p_eop);
          end
        end
        if (p_drf) begin
          n_cmp++;
          if (!(bus.drf_srdy === 1'b1 && bus.drf_page === p_drf_pg)) begin
            n_bad++; $display("FAIL drf_hold: srdy=%b page=%h, want 1/%h", bus.drf_srdy, bus.drf_page, p_drf_pg);
          end
        end
        if (f_ip) t_ip = cyc;
        if (f_rlp) begin
          n_cmp++;
          if (exp_rlp.size() == 0) begin
            n_bad++; $display("FAIL rlp_page: unexpected read of %h, want none", bus.rlp_page);
          end else begin
            e = exp_rlp.pop_front();
            if (bus.rlp_page !== e) begin n_bad++; $display("FAIL rlp_page: got %h, want %h", bus.rlp_page, e); end
            rsp_q.push_back(exp_lnk.pop_front());
          end
        end
        if (f_op) begin
          n_cmp++;
          if (exp_op.size() == 0) begin
            n_bad++; $display("FAIL op_page: unexpected output %h, want none", bus.op_page);
          end else begin
            eo = exp_op.pop_front();
            if ({bus.op_eop, bus.op_page} !== eo) begin
              n_bad++; $display("FAIL op_page: got eop=%b page=%h, want eop=%b page=%h", bus.op_eop, bus.op_page, eo[LPSZ], eo[LPSZ-1:0]);
            end
          end
        end
        if (f_drf) begin
          n_cmp++;
          if (exp_drf.size() == 0) begin
            n_bad++; $display("FAIL drf_page: unexpected free of %h, want none", bus.drf_page);
          end else begin
            e = exp_drf.pop_front();
            if (bus.drf_page !== e) begin n_bad++; $display("FAIL drf_page: got %h, want %h", bus.drf_page, e); end
            if (exp_last.pop_front()) model_cnt++;
          end
        end
        if (bus.pkt_done === 1'b1) begin
          done_cnt++;
          t_done = cyc;
          done_ipdrdy = bus.ip_drdy;
        end
        p_rlp = bus.rlp_srdy && !f_rlp; p_rlp_pg = bus.rlp_page;
        p_op  = bus.op_srdy && !f_op;   p_op_pg  = bus.op_page; p_eop = bus.op_eop;
        p_drf = bus.drf_srdy && !f_drf; p_drf_pg = bus.drf_page;
      end else begin
        p_rlp = 0; p_op = 0; p_drf = 0;
      end
      @(posedge clk);
      #1;
      if (reset) begin
        bus.ip_srdy = 1'b0;
        bus.rlpr_srdy = 1'b0;
        rsp_q.delete();
      end else begin
        if (f_ip) bus.ip_srdy = 1'b0;
        if (!bus.ip_srdy && hq.size() > 0 && int'($urandom_range(99)) >= bp) begin
          bus.ip_srdy = 1'b1;
          bus.ip_page = hq.pop_front();
        end
        if (f_rsp) bus.rlpr_srdy = 1'b0;
        if (!bus.rlpr_srdy && rsp_q.size() > 0 && int'($urandom_range(99)) >= bp) begin
          bus.rlpr_srdy = 1'b1;
          bus.rlpr_data = rsp_q.pop_front();
        end
      end
      bus.rlp_drdy = int'($urandom_range(99)) >= bp;
      bus.op_drdy  = !hold_op && int'($urandom_range(99)) >= bp;
      bus.drf_drdy = !hold_drf && int'($urandom_range(99)) >= bp;
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((hq.size() != 0 || exp_drf.size() != 0 || bus.ip_srdy || !bus.ip_drdy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_bad++; $display("FAIL %s_drain: timeout after %0d cycles, %0d pages pending, want 0", name, k, exp_drf.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({bus.rlp_srdy, bus.rlpr_drdy, bus.op_srdy, bus.drf_srdy} !== 4'b0) begin n_bad++; $display("FAIL reset_srdy: got %b, want 0000", {bus.rlp_srdy, bus.rlpr_drdy, bus.op_srdy, bus.drf_srdy}); end
    n_cmp++; if (bus.ip_drdy !== 1'b1) begin n_bad++; $display("FAIL reset_ip_drdy: got %b, want 1", bus.ip_drdy); end
    n_cmp++; if ({bus.op_eop, bus.pkt_done} !== 2'b0) begin n_bad++; $display("FAIL reset_flags: eop/done %b, want 00", {bus.op_eop, bus.pkt_done}); end
    n_cmp++; if ({bus.rlp_page, bus.op_page, bus.drf_page} !== '0) begin n_bad++; $display("FAIL reset_pages: got %h %h %h, want 0", bus.rlp_page, bus.op_page, bus.drf_page); end
    n_cmp++; if (bus.pkt_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d, want 0", bus.pkt_count); end
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ip_drdy !== 1'b1) begin n_bad++; $display("FAIL post_reset_ip_drdy: got %b, want 1", bus.ip_drdy); end
  endtask

  task automatic test_three_page();
    int d0 = done_cnt;
    bp = 0;
    add_pkt(3, 8'h05, 8'h07, 8'h09, 8'h00);
    wait_drain("three_page", 200);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL three_page_done: got %0d pulses, want 1", done_cnt - d0); end
    n_cmp++; if (t_done - t_ip !== 13) begin n_bad++; $display("FAIL three_page_latency: got %0d cycles, want 13", t_done - t_ip); end
    n_cmp++; if (bus.pkt_count !== exp_count()) begin n_bad++; $display("FAIL three_page_count: got %0d, want %0d", bus.pkt_count, exp_count()); end
  endtask

  task automatic test_single();
    int d0 = done_cnt;
    bp = 0;
    add_pkt(1, 8'h03, 8'h00, 8'h00, 8'h00);
    wait_drain("single", 100);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL single_done: got %0d pulses, want 1", done_cnt - d0); end
    n_cmp++; if (t_done - t_ip !== 5) begin n_bad++; $display("FAIL single_latency: got %0d cycles, want 5", t_done - t_ip); end
    n_cmp++; if (done_ipdrdy !== 1'b1) begin n_bad++; $display("FAIL single_ip_drdy: got %b with pkt_done, want 1", done_ipdrdy); end
  endtask

  task automatic test_free_stall();
    int k = 0;
    bp = 0;
    hold_drf = 1'b1;
    add_pkt(1, 8'h2A, 8'h00, 8'h00, 8'h00);
    while (bus.drf_srdy !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 50) begin n_bad++; $display("FAIL free_stall_reach: drf_srdy=%b after %0d cycles, want 1", bus.drf_srdy, k); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (!(bus.drf_srdy === 1'b1 && bus.drf_page === 8'h2A)) begin n_bad++; $display("FAIL free_stall_hold: srdy=%b page=%h, want 1/2a", bus.drf_srdy, bus.drf_page); end
      n_cmp++; if ({bus.ip_drdy, bus.rlp_srdy, bus.rlpr_drdy, bus.op_srdy} !== 4'b0) begin n_bad++; $display("FAIL free_stall_others: got %b, want 0000", {bus.ip_drdy, bus.rlp_srdy, bus.rlpr_drdy, bus.op_srdy}); end
      @(negedge clk);
    end
    hold_drf = 1'b0;
    wait_drain("free_stall", 100);
  endtask

  task automatic test_ignore_rsp();
    @(posedge clk); #2;
    bus.rlpr_data = 9'h1FF;
    bus.rlpr_srdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (!(bus.rlpr_drdy === 1'b0 && bus.ip_drdy === 1'b1)) begin n_bad++; $display("FAIL ignore_rsp: rlpr_drdy=%b ip_drdy=%b, want 0/1", bus.rlpr_drdy, bus.ip_drdy); end
    end
    @(posedge clk); #2;
    bus.rlpr_srdy = 1'b0;
    add_pkt(2, 8'h40, 8'h41, 8'h00, 8'h55);
    wait_drain("ignore_rsp", 100);
  endtask

  task automatic test_reset_mid();
    int k = 0;
    bp = 0;
    hold_op = 1'b1;
    add_pkt(3, 8'h10, 8'h11, 8'h12, 8'h00);
    while (bus.op_srdy !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 50) begin n_bad++; $display("FAIL reset_mid_reach: op_srdy=%b after %0d cycles, want 1", bus.op_srdy, k); end
    @(posedge clk); #2;
    reset = 1'b1;
    hq.delete(); exp_rlp.delete(); exp_lnk.delete(); exp_op.delete(); exp_drf.delete(); exp_last.delete();
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({bus.rlp_srdy, bus.rlpr_drdy, bus.op_srdy, bus.drf_srdy} !== 4'b0) begin n_bad++; $display("FAIL reset_mid_srdy: got %b, want 0000", {bus.rlp_srdy, bus.rlpr_drdy, bus.op_srdy, bus.drf_srdy}); end
    n_cmp++; if (bus.ip_drdy !== 1'b1) begin n_bad++; $display("FAIL reset_mid_ip_drdy: got %b, want 1", bus.ip_drdy); end
    n_cmp++; if (bus.pkt_count !== 16'd0) begin n_bad++; $display("FAIL reset_mid_count: got %0d, want 0", bus.pkt_count); end
    model_cnt = 0;
    @(posedge clk); #2;
    reset = 1'b0;
    hold_op = 1'b0;
    add_pkt(1, 8'h20, 8'h00, 8'h00, 8'hC3);
    wait_drain("reset_mid", 100);
    n_cmp++; if (bus.pkt_count !== exp_count()) begin n_bad++; $display("FAIL reset_mid_recount: got %0d, want %0d", bus.pkt_count, exp_count()); end
  endtask

  task automatic test_random();
    int d0 = done_cnt;
    int n;
    logic [LPSZ-1:0] base, tail;
    bp = 30;
    for (int i = 0; i < 1000; i++) begin
      n = int'($urandom_range(3, 1));
      base = LPSZ'($urandom_range(255));
      tail = LPSZ'($urandom_range(255));
      add_pkt(n, base, base + 8'd37, base + 8'd74, tail);
    end
    wait_drain("random", 60000);
    bp = 0;
    n_cmp++; if (done_cnt - d0 !== 1000) begin n_bad++; $display("FAIL random_done: got %0d pulses, want 1000", done_cnt - d0); end
    n_cmp++; if (bus.pkt_count !== exp_count()) begin n_bad++; $display("FAIL random_count: got %0d, want %0d", bus.pkt_count, exp_count()); end
    n_cmp++; if (exp_op.size() + exp_rlp.size() !== 0) begin n_bad++; $display("FAIL random_leftover: %0d entries pending, want 0", exp_op.size() + exp_rlp.size()); end
  endtask

  initial begin
    test_reset();
    test_three_page();
    test_single();
    test_free_stall();
    test_ignore_rsp();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
